img_frame_streamer: RTL and testbench

- Frame-buffer transmitter. Holds one grayscale frame written through a random-access write port, then emits it as a raster-order pixel stream with valid/ready handshake.
- Sits upstream of the edge-detection filters (Prewitt/Sobel) as their pixel source. This replaces file-based frame loading with a synthesizable streaming front end.
- Emits SOF, EOL and EOF markers, row/column coordinates and a border flag.

---
 rtl/img_pkg.sv | 23 ++
 rtl/frame_ram.sv | 34 +++
 rtl/img_frame_streamer.sv | 212 +++++++++++++++++++++
 tb/tb_img_frame_streamer.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared types and constants for the frame streamer: default frame geometry,
// pixel type, streaming FSM states and an index-width helper.
package img_pkg;

    localparam int ROWS_DEF    = 242;
    localparam int COLS_DEF    = 247;
    localparam int PIXEL_W_DEF = 8;

    typedef logic [PIXEL_W_DEF-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STREAM,
        DONE
    } stream_state_t;

    // Width of an index into n entries; never below 1 so 1x1 frames stay legal.
    function automatic int addr_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_ram.sv
// Single-port-write / single-port-read frame store with a registered read.
// No reset: contents survive a streamer reset so the stored frame can be replayed.
module frame_ram
    import img_pkg::*;
#(
    parameter int DATA_W = PIXEL_W_DEF,
    parameter int DEPTH  = ROWS_DEF * COLS_DEF,
    parameter int AW     = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read data holds while rd_en is low, which keeps a stalled beat stable.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/img_frame_streamer.sv
// Frame-buffer transmitter: random-access writes in IDLE, raster-order
// valid/ready pixel stream with SOF/EOL/EOF, coordinates and border flag.
// Build option BORDER_ZERO_EN: border beats carry zero data instead of the stored pixel.
module img_frame_streamer
    import img_pkg::*;
#(
    parameter int ROWS   = ROWS_DEF,
    parameter int COLS   = COLS_DEF,
    parameter int DATA_W = PIXEL_W_DEF,
    localparam int ROW_W = addr_width(ROWS),
    localparam int COL_W = addr_width(COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ROW_W-1:0]  wr_row,
    input  logic [COL_W-1:0]  wr_col,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_err,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof,
    output logic [ROW_W-1:0]  m_row,
    output logic [COL_W-1:0]  m_col,
    output logic              m_border
);

    localparam int AW = addr_width(ROWS * COLS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W:0]   ROW_LIM  = (ROW_W + 1)'(ROWS);
    localparam logic [COL_W:0]   COL_LIM  = (COL_W + 1)'(COLS);

    stream_state_t state_reg, state_next;

    logic              valid_reg;
    logic [ROW_W-1:0]  row_reg;
    logic [COL_W-1:0]  col_reg;
    logic [AW-1:0]     addr_reg;
    logic              wr_err_reg;

    logic              wr_in_range;
    logic              wr_accept;
    logic [AW-1:0]     wr_addr;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;

    logic              last_col;
    logic              last_row;
    logic              eof_beat;
    logic              border_beat;
    logic              accept;
    logic              zero_mask;

    // ------------------------------------------------------------------
    // Write port
    // ------------------------------------------------------------------
    assign wr_in_range = ({1'b0, wr_row} < ROW_LIM) && ({1'b0, wr_col} < COL_LIM);
    assign wr_accept   = wr_en && (state_reg == IDLE) && wr_in_range;
    assign wr_addr     = AW'(wr_row) * AW'(COLS) + AW'(wr_col);

    frame_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (ROWS * COLS),
        .AW     (AW)
    ) u_frame_ram (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // ------------------------------------------------------------------
    // Beat decode from registered coordinates
    // ------------------------------------------------------------------
    assign last_col    = (col_reg == LAST_COL);
    assign last_row    = (row_reg == LAST_ROW);
    assign eof_beat    = last_row && last_col;
    assign border_beat = (row_reg == '0) || last_row || (col_reg == '0) || last_col;
    assign accept      = valid_reg && m_ready;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The RAM output register is the beat data register; a new read is
    // launched exactly when the current beat leaves, giving 1 beat/cycle.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = addr_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                busy       = 1'b1;
                rd_en      = 1'b1;
                rd_addr    = '0;
                state_next = STREAM;
            end
            STREAM: begin
                busy = 1'b1;
                if (accept) begin
                    if (eof_beat) begin
                        state_next = DONE;
                    end else begin
                        rd_en = 1'b1;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Beat coordinates, read pointer and write error
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg  <= 1'b0;
            row_reg    <= '0;
            col_reg    <= '0;
            addr_reg   <= '0;
            wr_err_reg <= 1'b0;
        end else begin
            wr_err_reg <= wr_en && !wr_accept;
            case (state_reg)
                FETCH: begin
                    valid_reg <= 1'b1;
                    row_reg   <= '0;
                    col_reg   <= '0;
                    addr_reg  <= AW'(1);
                end
                STREAM: begin
                    if (accept) begin
                        if (eof_beat) begin
                            valid_reg <= 1'b0;
                            row_reg   <= '0;
                            col_reg   <= '0;
                            addr_reg  <= '0;
                        end else begin
                            addr_reg <= addr_reg + AW'(1);
                            if (last_col) begin
                                col_reg <= '0;
                                row_reg <= row_reg + ROW_W'(1);
                            end else begin
                                col_reg <= col_reg + COL_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stream outputs; sidebands and data are gated so idle outputs read zero
    // ------------------------------------------------------------------
`ifdef BORDER_ZERO_EN
    assign zero_mask = border_beat;
`else
    assign zero_mask = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_pix
            assign m_data[gi] = rd_data[gi] & valid_reg & ~zero_mask;
        end
    endgenerate

    assign m_valid  = valid_reg;
    assign m_row    = row_reg;
    assign m_col    = col_reg;
    assign m_sof    = valid_reg && (row_reg == '0) && (col_reg == '0);
    assign m_eol    = valid_reg && last_col;
    assign m_eof    = valid_reg && eof_beat;
    assign m_border = valid_reg && border_beat;
    assign wr_err   = wr_err_reg;

endmodule

// File: tb/tb_img_frame_streamer.sv
// Self-checking bench: 4x5 streamer with scoreboard, 1x1 corner instance and
// a full-size instance for beat counting and throughput.
module tb_img_frame_streamer;
    import img_pkg::*;

    localparam int R = 4;
    localparam int C = 5;
    localparam int BIG_BEATS = ROWS_DEF * COLS_DEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // 4x5 instance
    logic rst, wr_en, wr_err, start, busy, done, m_valid, m_ready;
    logic [1:0] wr_row, m_row;
    logic [2:0] wr_col, m_col;
    pixel_t wr_data, m_data;
    logic m_sof, m_eol, m_eof, m_border;

    img_frame_streamer #(.ROWS(R), .COLS(C), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data), .wr_err(wr_err), .start(start), .busy(busy), .done(done),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof),
        .m_eol(m_eol), .m_eof(m_eof), .m_row(m_row), .m_col(m_col), .m_border(m_border)
    );

    // 1x1 instance
    logic t_wr_en, t_wr_err, t_start, t_busy, t_done, t_valid, t_ready;
    logic t_wr_row, t_wr_col, t_row, t_col;
    pixel_t t_wr_data, t_data;
    logic t_sof, t_eol, t_eof, t_border;

    img_frame_streamer #(.ROWS(1), .COLS(1), .DATA_W(8)) dut_tiny (
        .clk(clk), .rst(rst), .wr_en(t_wr_en), .wr_row(t_wr_row), .wr_col(t_wr_col),
        .wr_data(t_wr_data), .wr_err(t_wr_err), .start(t_start), .busy(t_busy), .done(t_done),
        .m_valid(t_valid), .m_ready(t_ready), .m_data(t_data), .m_sof(t_sof),
        .m_eol(t_eol), .m_eof(t_eof), .m_row(t_row), .m_col(t_col), .m_border(t_border)
    );

    // full-size instance
    logic b_wr_en, b_wr_err, b_start, b_busy, b_done, b_valid, b_ready;
    logic [7:0] b_wr_row, b_wr_col, b_row, b_col;
    pixel_t b_wr_data, b_data;
    logic b_sof, b_eol, b_eof, b_border;

    img_frame_streamer dut_big (
        .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_row(b_wr_row), .wr_col(b_wr_col),
        .wr_data(b_wr_data), .wr_err(b_wr_err), .start(b_start), .busy(b_busy), .done(b_done),
        .m_valid(b_valid), .m_ready(b_ready), .m_data(b_data), .m_sof(b_sof),
        .m_eol(b_eol), .m_eof(b_eof), .m_row(b_row), .m_col(b_col), .m_border(b_border)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // side = {sof, eol, eof, border, row[1:0], col[2:0]}
    typedef struct {
        logic [7:0] data;
        logic [8:0] side;
    } beat_t;

    typedef struct {
        logic [1:0] row;
        logic [2:0] col;
        logic [7:0] data;
        logic       exp_err;
    } wvec_t;

    beat_t      exp_q[$];
    logic [7:0] model [R][C];
    int         beats_seen = 0;
    logic       rand_ready = 1'b0;
    int         s0 = 0;
    logic [8:0] cur_side;

    assign cur_side = {m_sof, m_eol, m_eof, m_border, m_row, m_col};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [8:0] side_of(input int r, input int c);
        logic s, e, f, b;
        s = (r == 0) && (c == 0);
        e = (c == C - 1);
        f = (r == R - 1) && (c == C - 1);
        b = (r == 0) || (r == R - 1) || (c == 0) || (c == C - 1);
        return {s, e, f, b, 2'(r), 3'(c)};
    endfunction

    task automatic push_frame();
        beat_t b;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                b.side = side_of(r, c);
                b.data = model[r][c];
`ifdef BORDER_ZERO_EN
                if (b.side[5]) b.data = 8'h00;
`endif
                exp_q.push_back(b);
            end
        end
    endtask

    // Output monitor: pops the scoreboard on every accepted beat and checks stalls hold.
    initial begin
        logic       hold_p;
        logic [7:0] hold_d;
        logic [8:0] hold_s;
        beat_t      e;
        hold_p = 1'b0;
        hold_d = '0;
        hold_s = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_p = 1'b0;
            end else begin
                if (hold_p) begin
                    check("hold_valid", 32'(m_valid), 1);
                    check("hold_data", 32'(m_data), 32'(hold_d));
                    check("hold_side", 32'(cur_side), 32'(hold_s));
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", m_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", 32'(m_data), 32'(e.data));
                        check("beat_side", 32'(cur_side), 32'(e.side));
                    end
                    beats_seen++;
                end
                hold_p = m_valid && !m_ready;
                hold_d = m_data;
                hold_s = cur_side;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_write(input int r, input int c, input logic [7:0] d, output logic err);
        wr_en   = 1'b1;
        wr_row  = 2'(r);
        wr_col  = 3'(c);
        wr_data = d;
        tick();
        wr_en = 1'b0;
        err   = wr_err;
    endtask

    task automatic wait_done(input int exp_lat);
        int k;
        for (k = 0; k < 400; k++) begin
            if (done) break;
            tick();
        end
        check("done_seen", 32'(done), 1);
        if (exp_lat >= 0) check("done_latency", cyc - s0, exp_lat);
        check("busy_at_done", 32'(busy), 0);
        check("queue_drained", exp_q.size(), 0);
        tick();
        check("done_pulse_width", 32'(done), 0);
    endtask

    task automatic run_frame(input int exp_lat);
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        s0 = cyc;
        check("busy_after_start", 32'(busy), 1);
        check("valid_latency_1", 32'(m_valid), 0);
        tick();
        check("valid_latency_2", 32'(m_valid), 1);
        wait_done(exp_lat);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_wr_err"}, 32'(wr_err), 0);
        check({tag, "_valid"}, 32'(m_valid), 0);
        check({tag, "_markers"}, 32'({m_sof, m_eol, m_eof, m_border}), 0);
        check({tag, "_data"}, 32'(m_data), 0);
        check({tag, "_row"}, 32'(m_row), 0);
        check({tag, "_col"}, 32'(m_col), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        wvec_t wv[6];
        logic  err;
        int    base, k, nv, neol, neof, nsof, first_v, done_c;

        // Row 4 is not representable on the 2-bit row port, so range errors use columns 5..7.
        wv[0] = '{2'd0, 3'd5, 8'h55, 1'b1};
        wv[1] = '{2'd0, 3'd7, 8'h56, 1'b1};
        wv[2] = '{2'd3, 3'd6, 8'h57, 1'b1};
        wv[3] = '{2'd2, 3'd5, 8'h58, 1'b1};
        wv[4] = '{2'd3, 3'd4, 8'd34, 1'b0};
        wv[5] = '{2'd0, 3'd0, 8'd0,  1'b0};

        rst = 1'b1; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
        start = 1'b0; m_ready = 1'b1;
        t_wr_en = 1'b0; t_wr_row = 1'b0; t_wr_col = 1'b0; t_wr_data = '0; t_start = 1'b0; t_ready = 1'b1;
        b_wr_en = 1'b0; b_wr_row = '0; b_wr_col = '0; b_wr_data = '0; b_start = 1'b0; b_ready = 1'b1;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Fill 4x5 frame with 10*row+col
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                model[r][c] = 8'(10 * r + c);
                do_write(r, c, model[r][c], err);
                check("fill_wr_err", 32'(err), 0);
            end
        end

        // Table-driven write vectors
        for (int i = 0; i < 6; i++) begin
            do_write(int'(wv[i].row), int'(wv[i].col), wv[i].data, err);
            check("wr_err_vec", 32'(err), 32'(wv[i].exp_err));
            if (!wv[i].exp_err) model[wv[i].row][wv[i].col] = wv[i].data;
            tick();
            check("wr_err_clear", 32'(wr_err), 0);
        end

        // Full-rate stream
        run_frame(21);

        // Random backpressure
        rand_ready = 1'b1;
        run_frame(-1);
        rand_ready = 1'b0;
        m_ready = 1'b1;
        tick();

        // Write while busy is rejected and does not disturb the stream
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        s0 = cyc;
        do_write(1, 1, 8'hEE, err);
        check("busy_wr_err", 32'(err), 1);
        wait_done(21);

        // Start and write together in IDLE: write lands before the stream reads it
        model[2][2] = 8'h77;
        push_frame();
        wr_en = 1'b1; wr_row = 2'd2; wr_col = 3'd2; wr_data = 8'h77;
        start = 1'b1;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        s0 = cyc;
        check("simul_wr_err", 32'(wr_err), 0);
        wait_done(21);

        // Reset after seven beats, then replay the stored frame
        push_frame();
        base = beats_seen;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (k = 0; k < 50; k++) begin
            if (beats_seen - base >= 7) break;
            tick();
        end
        check("beats_before_reset", beats_seen - base, 7);
        rst = 1'b1;
        m_ready = 1'b0;
        tick();
        check_idle_outputs("midrst");
        exp_q.delete();
        rst = 1'b0;
        m_ready = 1'b1;
        tick();
        base = beats_seen;
        run_frame(21);
        check("replay_beats", beats_seen - base, 20);

        // All-0xFF frame exercises the border path
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                model[r][c] = 8'hFF;
                do_write(r, c, 8'hFF, err);
            end
        end
        run_frame(21);

        // 1x1 frame: every marker on the single beat
        t_wr_en = 1'b1; t_wr_row = 1'b0; t_wr_col = 1'b0; t_wr_data = 8'hA5;
        tick();
        t_wr_en = 1'b0;
        check("tiny_wr_err_ok", 32'(t_wr_err), 0);
        t_wr_en = 1'b1; t_wr_row = 1'b1; t_wr_col = 1'b0; t_wr_data = 8'h11;
        tick();
        t_wr_en = 1'b0;
        check("tiny_wr_err_range", 32'(t_wr_err), 1);
        t_start = 1'b1;
        tick();
        t_start = 1'b0;
        check("tiny_busy", 32'(t_busy), 1);
        check("tiny_valid_early", 32'(t_valid), 0);
        tick();
        check("tiny_valid", 32'(t_valid), 1);
        check("tiny_markers", 32'({t_sof, t_eol, t_eof, t_border}), 32'hF);
`ifdef BORDER_ZERO_EN
        check("tiny_data", 32'(t_data), 0);
`else
        check("tiny_data", 32'(t_data), 32'hA5);
`endif
        tick();
        check("tiny_done", 32'(t_done), 1);
        check("tiny_valid_after", 32'(t_valid), 0);

        // Full-size frame: beat count, markers and throughput
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        nv = 0; neol = 0; neof = 0; nsof = 0; first_v = -1; done_c = -1;
        for (k = 0; k < BIG_BEATS + 100; k++) begin
            tick();
            if (b_done) begin
                done_c = cyc;
                break;
            end
            if (b_valid) begin
                if (first_v < 0) first_v = cyc;
                nv++;
                neol += int'(b_eol);
                neof += int'(b_eof);
                nsof += int'(b_sof);
            end
        end
        check("big_done_seen", 32'(done_c >= 0), 1);
        check("big_beats", nv, BIG_BEATS);
        check("big_eol", neol, ROWS_DEF);
        check("big_eof", neof, 1);
        check("big_sof", nsof, 1);
        check("big_throughput", done_c - first_v, BIG_BEATS);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
